// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: scheduler FSM states, default ALU widths and the opcode encoding shared with alu_fsm
package alu_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
  localparam int DEF_OP_W = 3;
  localparam int DEF_DATA_W = 4;
  localparam logic [DEF_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [DEF_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [DEF_OP_W-1:0] OP_AND = 3'd2;
  localparam logic [DEF_OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [DEF_OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [DEF_OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [DEF_OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [DEF_OP_W-1:0] OP_SHR = 3'd7;
endpackage

// File: rtl/alu_rr_scheduler_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant (req, ptr in; gnt out), searching upward from ptr+1 with wrap
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [PW:0]  s;
  logic [N-1:0] rot;
  logic [N-1:0] low;
  assign s = {1'b0, ptr} + (PW+1)'(1);
  assign rot = N'({req, req} >> s);
  assign low = rot & (~rot + N'(1));
  assign gnt = N'((({low, low}) << s) >> N);
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one alu_fsm among NUM_REQ requesters (req_* in/ready out, rsp_* out, alu_* to/from the ALU, busy)
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OP_W = DEF_OP_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_error,
  output logic                      alu_start,
  output logic [OP_W-1:0]           alu_opcode,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic                      alu_done,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC);
  sched_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
  logic [TW-1:0] timer_q, timer_d;
  logic [NUM_REQ-1:0] gnt, rsp_valid_q, rsp_valid_d;
  logic [OP_W-1:0] alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_result_q, rsp_result_d;
  logic alu_start_q, alu_start_d, rsp_error_q, rsp_error_d, busy_q, busy_d;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req_valid), .ptr(ptr_q), .gnt(gnt));
  assign req_ready = (state_q == IDLE) ? gnt : '0;
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) win = IW'(i);
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    timer_d = timer_q;
    alu_start_d = 1'b0;
    alu_opcode_d = alu_opcode_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    rsp_valid_d = '0;
    rsp_result_d = '0;
    rsp_error_d = 1'b0;
    case (state_q)
      IDLE: if (|req_ready) begin
        state_d = ISSUE;
        idx_d = win;
        alu_start_d = 1'b1;
        alu_opcode_d = req_opcode[win*OP_W +: OP_W];
        alu_a_d = req_a[win*DATA_W +: DATA_W];
        alu_b_d = req_b[win*DATA_W +: DATA_W];
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (alu_done || timer_q == TW'(TIMEOUT_CYC-1)) begin
        state_d = RESP;
        rsp_valid_d = NUM_REQ'(1) << idx_q;
        rsp_error_d = !alu_done;
        rsp_result_d = alu_done ? alu_result : '0;
      end else timer_d = timer_q + TW'(1);
      RESP: begin
        state_d = IDLE;
        ptr_d = idx_q;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= IW'(NUM_REQ-1);
      idx_q <= '0;
      timer_q <= '0;
      alu_start_q <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      rsp_valid_q <= '0;
      rsp_result_q <= '0;
      rsp_error_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
      alu_start_q <= alu_start_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q <= rsp_error_d;
      busy_q <= busy_d;
    end
  end
  assign alu_start = alu_start_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error = rsp_error_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed self-checking bench for alu_rr_scheduler with a hand-driven ALU stub
module tb_alu_rr_scheduler;
  localparam int TO = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [3:0] req_valid = '0, req_ready, rsp_valid;
  logic [11:0] req_opcode;
  logic [15:0] req_a, req_b;
  logic [3:0] rsp_result, alu_a, alu_b, alu_result = '0;
  logic [2:0] alu_opcode;
  logic rsp_error, alu_start, alu_done = 1'b0, busy;
  logic [2:0] op_t [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
  logic [3:0] a_t [4] = '{4'd10, 4'd9, 4'd12, 4'd6};
  logic [3:0] b_t [4] = '{4'd5, 4'd3, 4'd10, 4'd3};
  logic [3:0] res_t [4] = '{4'd15, 4'd6, 4'd8, 4'd5};
  int checks = 0, errors = 0;
  assign req_opcode = {op_t[3], op_t[2], op_t[1], op_t[0]};
  assign req_a = {a_t[3], a_t[2], a_t[1], a_t[0]};
  assign req_b = {b_t[3], b_t[2], b_t[1], b_t[0]};
  always #5 clk = ~clk;
  alu_rr_scheduler #(.NUM_REQ(4), .OP_W(3), .DATA_W(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_start"}, alu_start, 0);
    chk({tag, "_op"}, alu_opcode, 0);
    chk({tag, "_a"}, alu_a, 0);
    chk({tag, "_b"}, alu_b, 0);
    chk({tag, "_rsp"}, rsp_valid, 0);
    chk({tag, "_res"}, rsp_result, 0);
    chk({tag, "_err"}, rsp_error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, req_ready, 0);
  endtask
  // Called on a falling edge while the scheduler is IDLE. lat<0 keeps alu_done low to force a timeout;
  // stale raises alu_done with a decoy result during ISSUE only.
  task automatic serve(input logic [3:0] vmask, input int w, input logic [3:0] res, input int lat, input bit stale);
    req_valid = vmask;
    #1;
    chk("grant", req_ready, 4'b1 << w);
    @(negedge clk);
    chk("start", alu_start, 1);
    chk("busy_issue", busy, 1);
    chk("ready_issue", req_ready, 0);
    chk("alu_op", alu_opcode, op_t[w]);
    chk("alu_a", alu_a, a_t[w]);
    chk("alu_b", alu_b, b_t[w]);
    if (stale) begin
      alu_done = 1'b1;
      alu_result = 4'h7;
    end
    @(negedge clk);
    alu_done = 1'b0;
    chk("start_once", alu_start, 0);
    chk("ready_wait", req_ready, 0);
    if (lat < 0) begin
      alu_result = 4'hf;
      repeat (TO-1) @(negedge clk);
      chk("no_rsp_before_to", rsp_valid, 0);
      @(negedge clk);
      chk("to_err", rsp_error, 1);
      chk("to_res", rsp_result, 0);
    end else begin
      repeat (lat) @(negedge clk);
      alu_done = 1'b1;
      alu_result = res;
      @(negedge clk);
      alu_done = 1'b0;
      chk("rsp_err", rsp_error, 0);
      chk("rsp_res", rsp_result, res);
    end
    chk("rsp_valid", rsp_valid, 4'b1 << w);
    chk("ready_resp", req_ready, 0);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("busy_idle", busy, 0);
    req_valid = '0;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1 chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    serve(4'b0001, 0, 4'd15, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 7; k++) serve(4'b1111, k % 4, res_t[k % 4], k % 3, 1'b0);
    serve(4'b0101, 0, 4'd15, 1, 1'b0);
    serve(4'b0010, 1, 4'd0, -1, 1'b0);
    serve(4'b0010, 1, 4'd6, 3, 1'b0);
    serve(4'b0010, 1, 4'd6, TO-1, 1'b0);
    req_valid = 4'b0100;
    #1 chk("grant_rst", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("busy_wait", busy, 1);
    rst_n = 1'b0;
    #1 chk_idle("midreset");
    repeat (2) begin
      @(negedge clk);
      chk("rsp_in_reset", rsp_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rsp_after_reset", rsp_valid, 0);
    serve(4'b1111, 0, 4'd15, 0, 1'b0);
    serve(4'b0001, 0, 4'd9, 2, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
